cnt_sched: RTL

- Scheduler that shares one 8-bit loadable counter (active-low synchronous set_n, 8-bit load, 8-bit count) between NREQ requesters.
- Each requester supplies a start value. The block arbitrates round-robin and loads the winner's value into the counter.
- It then monitors the count until it reaches TERMINAL and returns a done pulse to the owner.
- It sits between client logic and the counter and is the only driver of the counter's set_n/load.

---
 rtl/cnt_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/cnt_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared types and constants for the counter scheduler.
// This package holds the FSM state encoding, the counter width and the default terminal count.
package cnt_sched_pkg;

    localparam int unsigned         CNT_W        = 8;
    localparam logic [CNT_W-1:0]    TERMINAL_DEF = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// It returns the lowest requester index at or after ptr_i, wrapping modulo NREQ.
// The caller owns the pointer register.
module rr_arbiter
    import cnt_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   win_o
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan from the pointer upward and take the first active request.
    always_comb begin
        gnt_o = '0;
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PW'((32'(ptr_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = idx;
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: round-robin scheduler that shares one 8-bit loadable counter
// among NREQ requesters. It loads the winner's start value into the counter,
// waits for TERMINAL and then pulses done to the owner.
// When CNT_SCHED_WDOG_EN is defined, a stall watchdog aborts a run whose count
// stops changing for WDOG_CYC cycles. The abort is signalled on err_o.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int unsigned      NREQ     = 2,
    parameter logic [CNT_W-1:0] TERMINAL = TERMINAL_DEF,
    parameter int unsigned      WDOG_CYC = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [CNT_W*NREQ-1:0] val_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic [NREQ-1:0]       err_o,
    output logic                  busy_o,
    output logic                  set_n_o,
    output logic [CNT_W-1:0]      load_o,
    input  logic [CNT_W-1:0]      count_i
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic             set_n_q, set_n_d;
    logic [CNT_W-1:0] load_q, load_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [PW-1:0]    arb_win;
    logic [CNT_W-1:0] val_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_val
        assign val_a[g] = val_i[g*CNT_W +: CNT_W];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .win_o (arb_win)
    );

`ifdef CNT_SCHED_WDOG_EN
    localparam int unsigned SW = $clog2(WDOG_CYC + 1);

    logic [SW-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0] prev_q;
    logic [NREQ-1:0]  err_q, err_d;
`endif

    // Next-state and registered-output logic for the IDLE/LOAD/RUN sequence.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        done_d  = '0;
        set_n_d = 1'b1;
        load_d  = load_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef CNT_SCHED_WDOG_EN
        err_d   = '0;
        stall_d = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    owner_d = arb_win;
                    load_d  = val_a[arb_win];
                    gnt_d   = arb_gnt;
                    set_n_d = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                state_d = RUN;
            end
            RUN: begin
`ifdef CNT_SCHED_WDOG_EN
                stall_d = (count_i == prev_q) ? stall_q + 1'b1 : '0;
`endif
                if (count_i == TERMINAL) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
`ifdef CNT_SCHED_WDOG_EN
                else if (stall_d == SW'(WDOG_CYC)) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            set_n_q <= 1'b1;
            load_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            set_n_q <= set_n_d;
            load_q  <= load_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef CNT_SCHED_WDOG_EN
    // Stall watchdog registers. prev_q tracks every cycle so the first RUN cycle compares against the count seen during LOAD.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            prev_q  <= '0;
            err_q   <= '0;
        end else begin
            stall_q <= stall_d;
            prev_q  <= count_i;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;
    assign set_n_o = set_n_q;
    assign load_o  = load_q;

endmodule
